// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM encoding and FIPS-197 vectors for the AES round sequencer
// Contents: AES_BW block width, NR_AES128/192/256 round counts, state_e FSM encoding,
//           FIPS-197 appendix C.1 key/plaintext/ciphertext.
package aes_pkg;
    localparam int AES_BW    = 128;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_WAIT,
        S_ARK,
        S_SB,
        S_SR,
        S_MC,
        S_DONE
    } state_e;

    localparam logic [AES_BW-1:0] FIPS197_KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_BW-1:0] FIPS197_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [AES_BW-1:0] FIPS197_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
endpackage

// File: rtl/aes_stage_timer.sv
// aes_stage_timer: per-stage cycle counter giving the enable (first) and capture (last) cycles
// Ports: clk, rst (sync, active-high); clr_i zeroes the count for the next cycle;
//        first_o is high when the count is 0, last_o when it equals STAGE_LAT.
module aes_stage_timer #(
    parameter int STAGE_LAT = 1,
    localparam int W = (STAGE_LAT < 1) ? 1 : $clog2(STAGE_LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic first_o,
    output logic last_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d   = clr_i ? '0 : cnt_q + W'(1);
    assign first_o = cnt_q == '0;
    assign last_o  = cnt_q == W'(STAGE_LAT);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: sequences one AES encryption across external SB/SR/MC/ARK stage datapaths
// Ports: start_i/plaintext_i accept a block in IDLE; rk_req_o/rk_valid_i/round_key_i fetch the key
//        for round_idx_o; stage_state_o/stage_key_o feed the stages, *_en_o pulse each stage once,
//        *_out_i are captured STAGE_LAT cycles later; ciphertext_o/done_o report the result, busy_o
//        covers the whole operation.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int word_size  = 8,
    parameter int array_size = 16,
    parameter int NR         = NR_AES128,
    parameter int STAGE_LAT  = 1,
    localparam int BW = word_size * array_size
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [BW-1:0] plaintext_i,
    output logic          rk_req_o,
    input  logic          rk_valid_i,
    input  logic [BW-1:0] round_key_i,
    output logic [3:0]    round_idx_o,
    output logic [BW-1:0] stage_state_o,
    output logic [BW-1:0] stage_key_o,
    output logic          sb_en_o,
    output logic          sr_en_o,
    output logic          mc_en_o,
    output logic          ark_en_o,
    input  logic [BW-1:0] sb_out_i,
    input  logic [BW-1:0] sr_out_i,
    input  logic [BW-1:0] mc_out_i,
    input  logic [BW-1:0] ark_out_i,
    output logic [BW-1:0] ciphertext_o,
    output logic          busy_o,
    output logic          done_o
);
    state_e        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [BW-1:0] data_q, data_d;
    logic [BW-1:0] key_q, key_d;
    logic [BW-1:0] ct_q, ct_d;
    logic          in_stage, first, last;

    assign in_stage = state_q inside {S_ARK, S_SB, S_SR, S_MC};

    // Held at zero outside stage states and wrapped on capture, so every stage starts at cnt==0.
    aes_stage_timer #(.STAGE_LAT(STAGE_LAT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!in_stage || last),
        .first_o (first),
        .last_o  (last)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        key_d   = key_q;
        ct_d    = ct_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                data_d  = plaintext_i;
                round_d = '0;
                state_d = S_KEY_WAIT;
            end
            S_KEY_WAIT: if (rk_valid_i) begin
                key_d   = round_key_i;
                state_d = S_ARK;
            end
            S_ARK: if (last) begin
                data_d = ark_out_i;
                if (round_q == 4'(NR)) begin
                    // Captured here so ciphertext is already valid while done is high.
                    ct_d    = ark_out_i;
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = S_SB;
                end
            end
            S_SB: if (last) begin
                data_d  = sb_out_i;
                state_d = S_SR;
            end
            S_SR: if (last) begin
                data_d  = sr_out_i;
                state_d = (round_q < 4'(NR)) ? S_MC : S_KEY_WAIT;
            end
            S_MC: if (last) begin
                data_d  = mc_out_i;
                state_d = S_KEY_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            data_q  <= '0;
            key_q   <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
        end
    end

    assign rk_req_o      = state_q == S_KEY_WAIT;
    assign round_idx_o   = round_q;
    assign stage_state_o = data_q;
    assign stage_key_o   = key_q;
    assign ark_en_o      = (state_q == S_ARK) && first;
    assign sb_en_o       = (state_q == S_SB) && first;
    assign sr_en_o       = (state_q == S_SR) && first;
    assign mc_en_o       = (state_q == S_MC) && first;
    assign ciphertext_o  = ct_q;
    assign busy_o        = state_q != S_IDLE;
    assign done_o        = state_q == S_DONE;
endmodule
